// File: rtl/bus_clk_gating_mc.sv
// Multi-channel bus clock gating controller: per-channel RUN/HOLD/GATED enable FSMs with idle
// hysteresis, optional activity synchronisers and a domain stop request/acknowledge handshake.

// Glitch-free gate: the enable is captured while raw clock is low, so the AND only changes in the low phase.
module BB_clk_gating (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic bypass,
   output logic gen_clk
);
   logic en_lat;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) en_lat <= 1'b1;
      else        en_lat <= en | bypass;
   end

   assign gen_clk = clk & en_lat;
endmodule

module bus_clk_gating_mc #(
   parameter int                CH_NUM     = 4,
   parameter logic [CH_NUM-1:0] SYNC_MASK  = '0,
   parameter int                SYNC_STAGE = 2,
   parameter int                IDLE_CNT_W = 4
) (
   input  logic                  raw_clk,
   input  logic                  rst_n,
   input  logic [CH_NUM-1:0]     active,
   input  logic                  bypass,
   input  logic [IDLE_CNT_W-1:0] idle_thr,
   input  logic                  stop_req,
   output logic                  stop_ack,
   output logic [CH_NUM-1:0]     gen_clk,
   output logic [CH_NUM-1:0]     clk_en_sts
);
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_GATED = 2'd2
   } state_t;

   localparam logic [IDLE_CNT_W-1:0] CNT_ONE = IDLE_CNT_W'(1);

   logic [CH_NUM-1:0] sync_active;
   logic [CH_NUM-1:0] eff_act;
   logic [CH_NUM-1:0] gated;
   logic [CH_NUM-1:0] en_q;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      state_t                state_q, state_d;
      logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;

      if (SYNC_MASK[i]) begin : g_sync
         logic [SYNC_STAGE-1:0] sync_q;

         always_ff @(posedge raw_clk or negedge rst_n) begin
            if (!rst_n) sync_q <= '0;
            else        sync_q <= {sync_q[SYNC_STAGE-2:0], active[i]};
         end

         assign sync_active[i] = sync_q[SYNC_STAGE-1];
      end else begin : g_direct
         assign sync_active[i] = active[i];
      end

      // A stop request looks like idleness, so channels run their normal hysteresis before gating.
      assign eff_act[i] = sync_active[i] & ~stop_req;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            ST_RUN: begin
               if (!eff_act[i]) begin
                  if (idle_thr == '0) begin
                     state_d = ST_GATED;
                  end else begin
                     state_d = ST_HOLD;
                     cnt_d   = idle_thr - CNT_ONE;
                  end
               end
            end
            ST_HOLD: begin
               if (eff_act[i])          state_d = ST_RUN;
               else if (cnt_q == '0)    state_d = ST_GATED;
               else                     cnt_d   = cnt_q - CNT_ONE;
            end
            ST_GATED: begin
               if (eff_act[i]) state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end

      // Enable is its own flop so the gate cell never sees state-decode hazards.
      always_ff @(posedge raw_clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            en_q[i] <= 1'b1;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q[i] <= (state_d != ST_GATED);
         end
      end

      assign gated[i] = (state_q == ST_GATED);

      BB_clk_gating u_icg (
         .clk     (raw_clk),
         .rst_n   (rst_n),
         .en      (en_q[i]),
         .bypass  (bypass),
         .gen_clk (gen_clk[i])
      );
   end

   always_ff @(posedge raw_clk or negedge rst_n) begin
      if (!rst_n) stop_ack <= 1'b0;
      else        stop_ack <= stop_req & (&gated);
   end

   assign clk_en_sts = en_q;
endmodule

// File: tb/tb_bus_clk_gating_mc.sv
// Bench for bus_clk_gating_mc: directed scenarios then random traffic, all checked cycle by cycle
// against an idle-run-length model of the enable, stop_ack and gated-clock behaviour.
module tb_bus_clk_gating_mc;
   localparam int         CH   = 4;
   localparam int         S    = 2;
   localparam int         TW   = 4;
   localparam logic [3:0] MASK = 4'b1000;

   logic          raw_clk;
   logic          rst_n;
   logic [CH-1:0] active;
   logic          bypass;
   logic [TW-1:0] idle_thr;
   logic          stop_req;
   logic          stop_ack;
   logic [CH-1:0] gen_clk;
   logic [CH-1:0] clk_en_sts;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a channel's enable is low once its run of idle samples exceeds the threshold taken at the run start.
   logic [CH-1:0] m_en;
   logic [CH-1:0] m_gen;
   logic          m_ack;
   int            run_len [CH];
   int            thr_lat [CH];
   logic [CH-1:0] hist [$];

   bus_clk_gating_mc #(
      .CH_NUM     (CH),
      .SYNC_MASK  (MASK),
      .SYNC_STAGE (S),
      .IDLE_CNT_W (TW)
   ) dut (
      .raw_clk    (raw_clk),
      .rst_n      (rst_n),
      .active     (active),
      .bypass     (bypass),
      .idle_thr   (idle_thr),
      .stop_req   (stop_req),
      .stop_ack   (stop_ack),
      .gen_clk    (gen_clk),
      .clk_en_sts (clk_en_sts)
   );

   initial raw_clk = 1'b0;
   always #5 raw_clk = ~raw_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_en  = '1;
      m_gen = '1;
      m_ack = 1'b0;
      hist.delete();
      for (int k = 0; k < S; k++) hist.push_back('0);
      for (int c = 0; c < CH; c++) begin
         run_len[c] = 0;
         thr_lat[c] = 0;
      end
   endtask

   task automatic model_edge();
      logic [CH-1:0] dly;
      logic          all_gated;
      logic          s;
      dly = hist.pop_front();
      hist.push_back(active);
      all_gated = (m_en == '0);
      for (int c = 0; c < CH; c++) begin
         s = MASK[c] ? dly[c] : active[c];
         if (s && !stop_req) begin
            run_len[c] = 0;
            m_en[c]    = 1'b1;
         end else begin
            if (run_len[c] == 0) thr_lat[c] = int'(idle_thr);
            if (run_len[c] < 1000) run_len[c]++;
            m_en[c] = (run_len[c] <= thr_lat[c]);
         end
      end
      m_ack = stop_req & all_gated;
   endtask

   // One full cycle: model at the rising edge, checks in the high and low phases; returns at negedge+1.
   task automatic tick();
      @(posedge raw_clk);
      model_edge();
      #1;
      chk("clk_en_sts", 32'(clk_en_sts), 32'(m_en));
      chk("stop_ack", 32'(stop_ack), 32'(m_ack));
      chk("gen_clk_high", 32'(gen_clk), 32'(m_gen));
      @(negedge raw_clk);
      m_gen = m_en | {CH{bypass}};
      #1;
      chk("gen_clk_low", 32'(gen_clk), 32'd0);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_async_en", 32'(clk_en_sts), 32'hf);
      chk("rst_async_ack", 32'(stop_ack), 32'd0);
      model_reset();
      @(posedge raw_clk);
      #1;
      chk("rst_gen_high", 32'(gen_clk), 32'hf);
      @(negedge raw_clk);
      #1;
      chk("rst_gen_low", 32'(gen_clk), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      active   = '0;
      bypass   = 1'b0;
      idle_thr = 4'd3;
      stop_req = 1'b0;
      model_reset();
      @(negedge raw_clk);
      #1;
      chk("reset_en", 32'(clk_en_sts), 32'hf);
      chk("reset_ack", 32'(stop_ack), 32'd0);
      @(posedge raw_clk);
      #1;
      chk("reset_gen", 32'(gen_clk), 32'hf);
      @(negedge raw_clk);
      #1;
      rst_n = 1'b1;

      // Idle out of reset with threshold 3: enable held for E0..E0+2, low after E0+3.
      ticks(3);
      chk("t1_hold", 32'(clk_en_sts), 32'hf);
      tick();
      chk("t1_gated", 32'(clk_en_sts), 32'h0);
      ticks(2);
      chk("t1_no_ack", 32'(stop_ack), 32'd0);

      // Threshold 0, one-cycle activity gap on channel 1.
      idle_thr = 4'd0;
      active   = 4'b0010;
      ticks(2);
      active = 4'b0000;
      tick();
      chk("t2_fall", 32'(clk_en_sts[1]), 32'd0);
      active = 4'b0010;
      tick();
      chk("t2_rise", 32'(clk_en_sts[1]), 32'd1);

      // Re-activation inside HOLD restarts the full countdown on the next drop.
      idle_thr = 4'd5;
      active   = 4'b0100;
      ticks(2);
      active = 4'b0000;
      ticks(2);
      active = 4'b0100;
      ticks(2);
      chk("t3_never_fell", 32'(clk_en_sts[2]), 32'd1);
      active = 4'b0000;
      ticks(5);
      chk("t3_hold5", 32'(clk_en_sts[2]), 32'd1);
      tick();
      chk("t3_gated", 32'(clk_en_sts[2]), 32'd0);

      // Synchronised channel 3 wakes three edges after activity rises.
      ticks(3);
      active = 4'b1000;
      ticks(2);
      chk("t4_sync_wait", 32'(clk_en_sts[3]), 32'd0);
      tick();
      chk("t4_sync_rise", 32'(clk_en_sts[3]), 32'd1);

      // Stop request with every channel busy.
      active   = 4'b1111;
      idle_thr = 4'd2;
      ticks(4);
      stop_req = 1'b1;
      ticks(2);
      chk("t5_still_on", 32'(clk_en_sts), 32'hf);
      tick();
      chk("t5_all_gated", 32'(clk_en_sts), 32'h0);
      chk("t5_ack_late", 32'(stop_ack), 32'd0);
      tick();
      chk("t5_ack", 32'(stop_ack), 32'd1);
      stop_req = 1'b0;
      tick();
      chk("t5_ack_drop", 32'(stop_ack), 32'd0);
      chk("t5_resume", 32'(clk_en_sts), 32'hf);

      // Bypass while gated, then reset in the middle of HOLD.
      active = 4'b0000;
      ticks(4);
      bypass = 1'b1;
      ticks(2);
      chk("t6_byp_en", 32'(clk_en_sts), 32'h0);
      bypass   = 1'b0;
      idle_thr = 4'd5;
      active   = 4'b1111;
      ticks(4);
      active = 4'b0000;
      ticks(2);
      pulse_reset();
      ticks(2);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 3) == 0) active[c] = ~active[c];
         if ($urandom_range(0, 15) == 0) stop_req = ~stop_req;
         if ($urandom_range(0, 7) == 0)  idle_thr = TW'($urandom_range(0, 6));
         if ($urandom_range(0, 19) == 0) bypass = ~bypass;
         if ($urandom_range(0, 149) == 0) pulse_reset();
         else tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
